i2s_audio_tx: RTL and testbench

//  I2S transmitter clocked by the audio PLL output (pll_audio clkout0). Buffers stereo
//  PCM from the sound core in a small FIFO and serialises it to the DAC as BCLK/LRCK/SDATA.

---
 rtl/i2s_audio_tx.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_i2s_audio_tx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_tx.sv
// ----------------------------------------------------------------------------
// i2s_audio_tx
//
// I2S transmitter that runs on the audio PLL clock. The sound core pushes
// stereo PCM samples into a small FIFO. This block serialises them to the DAC
// as BCLK / LRCK / SDATA. While the PLL is not locked the block stays idle,
// holds every serial line low and discards anything still buffered.
//
// Parameters
//   CLK_DIV     clk cycles per BCLK half-period (>= 1)
//   SAMPLE_W    PCM bits per channel
//   SLOT_W      BCLK cycles per channel slot (>= SAMPLE_W)
//   FIFO_DEPTH  stereo-sample FIFO entries (power of 2, >= 2)
//
// Ports
//   clk           audio clock (PLL clkout0)
//   reset         asynchronous, active-high
//   pll_lock      PLL lock (asynchronous, synchronised here with 2 flops)
//   in_valid      sample valid from the sound core
//   in_ready      FIFO can accept a sample this cycle
//   in_left       left PCM sample, two's complement
//   in_right      right PCM sample, two's complement
//   i2s_bclk      bit clock
//   i2s_lrck      word select, 0 = left channel
//   i2s_sdata     serial data, MSB first, changes after BCLK falling edges
//   underrun      one-cycle pulse when a frame starts with the FIFO empty
//   underrun_cnt  saturating count of underruns (cleared by reset only)
//   fifo_level    number of samples currently buffered
// ----------------------------------------------------------------------------
module i2s_audio_tx #(
    parameter int CLK_DIV    = 4,
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pll_lock,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SAMPLE_W-1:0]           in_left,
    input  logic [SAMPLE_W-1:0]           in_right,
    output logic                          i2s_bclk,
    output logic                          i2s_lrck,
    output logic                          i2s_sdata,
    output logic                          underrun,
    output logic [7:0]                    underrun_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_W);

    localparam logic [AW:0]      FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]      LEVEL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]    PTR_ONE    = AW'(1);
    localparam logic [DIV_W-1:0] LAST_DIV   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
    localparam logic [BIT_W-1:0] SAMPLE_IDX = BIT_W'(SAMPLE_W);
    localparam logic [BIT_W-1:0] SLOT_IDX   = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] LRCK_ON    = BIT_W'(SLOT_W - 1);
    localparam logic [BIT_W-1:0] LRCK_OFF   = BIT_W'(2 * SLOT_W - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic lock_meta;
    logic lock_s;

    logic [2*SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [2*SAMPLE_W-1:0] head;
    logic [SAMPLE_W-1:0]   head_left;
    logic [SAMPLE_W-1:0]   head_right;
    logic                  fifo_empty;

    logic [SAMPLE_W-1:0]   left_reg;
    logic [SAMPLE_W-1:0]   right_reg;
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BIT_W-1:0]      bit_next;

    logic start_run;
    logic bclk_fall;
    logic frame_wrap;
    logic flush;
    logic push;
    logic pop;

    logic [SAMPLE_W-1:0] load_left;
    logic [SAMPLE_W-1:0] load_right;

    // Serial data bit for slot position k: left word MSB first at the start
    // of the first slot, right word MSB first at the start of the second slot,
    // zero padding in the remainder of each slot.
    function automatic logic sdata_bit(
        input logic [BIT_W-1:0]    k,
        input logic [SAMPLE_W-1:0] l,
        input logic [SAMPLE_W-1:0] r
    );
        logic [SAMPLE_W-1:0] sh;
        logic [BIT_W-1:0]    kr;
        sdata_bit = 1'b0;
        sh        = '0;
        kr        = k - SLOT_IDX;
        if (k < SAMPLE_IDX) begin
            sh        = l << k;
            sdata_bit = sh[SAMPLE_W-1];
        end else if ((k >= SLOT_IDX) && (kr < SAMPLE_IDX)) begin
            sh        = r << kr;
            sdata_bit = sh[SAMPLE_W-1];
        end
    endfunction

    // Word select leads the data by one BCLK so the DAC sees the channel
    // change one bit before each MSB.
    function automatic logic lrck_bit(input logic [BIT_W-1:0] k);
        lrck_bit = (k >= LRCK_ON) && (k <= LRCK_OFF);
    endfunction

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    assign head       = mem[rd_ptr];
    assign head_left  = head[2*SAMPLE_W-1:SAMPLE_W];
    assign head_right = head[SAMPLE_W-1:0];
    assign fifo_empty = (fifo_level == '0);

    // in_ready depends only on registered state, so there is no path from any
    // input to any output.
    assign in_ready = (state != ST_IDLE) && (fifo_level < FULL_LEVEL);
    assign push     = in_valid && in_ready;
    assign flush    = !lock_s;

    assign bit_next = (bit_cnt == LAST_BIT) ? '0 : (bit_cnt + BIT_ONE);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the strobes that steer the datapath. Losing lock from
    // any state returns to IDLE.
    always_comb begin
        state_next = state;
        start_run  = 1'b0;
        bclk_fall  = 1'b0;
        frame_wrap = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (lock_s) begin
                    state_next = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (!lock_s) begin
                    state_next = ST_IDLE;
                end else if (!fifo_empty) begin
                    state_next = ST_RUN;
                    start_run  = 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_next = ST_IDLE;
                end else if ((div_cnt == LAST_DIV) && i2s_bclk) begin
                    bclk_fall  = 1'b1;
                    frame_wrap = (bit_cnt == LAST_BIT);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign pop = start_run || (frame_wrap && !fifo_empty);

    // A frame that starts with nothing buffered plays silence.
    assign load_left  = fifo_empty ? '0 : head_left;
    assign load_right = fifo_empty ? '0 : head_right;

    // FIFO storage. Writes issued during a flush land in a slot that is
    // immediately abandoned because the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_left, in_right};
        end
    end

    // FIFO pointers and occupancy. A simultaneous push and pop leaves the
    // level unchanged while both pointers still advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LEVEL_ONE;
                2'b01:   fifo_level <= fifo_level - LEVEL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Serialiser: BCLK divider, bit position and the registered serial lines.
    // Data and word select only move on BCLK falling edges so the DAC samples
    // them stable on the rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_reg  <= '0;
            right_reg <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrck  <= 1'b0;
            i2s_sdata <= 1'b0;
            underrun  <= 1'b0;
        end else if (flush) begin
            left_reg  <= '0;
            right_reg <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrck  <= 1'b0;
            i2s_sdata <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (start_run) begin
                left_reg  <= head_left;
                right_reg <= head_right;
                div_cnt   <= '0;
                bit_cnt   <= '0;
                i2s_bclk  <= 1'b0;
                i2s_lrck  <= 1'b0;
                i2s_sdata <= head_left[SAMPLE_W-1];
            end else if (state == ST_RUN) begin
                if (div_cnt == LAST_DIV) begin
                    div_cnt  <= '0;
                    i2s_bclk <= !i2s_bclk;
                end else begin
                    div_cnt <= div_cnt + DIV_ONE;
                end
                if (bclk_fall) begin
                    bit_cnt  <= bit_next;
                    i2s_lrck <= lrck_bit(bit_next);
                    if (frame_wrap) begin
                        left_reg  <= load_left;
                        right_reg <= load_right;
                        i2s_sdata <= sdata_bit(bit_next, load_left, load_right);
                        underrun  <= fifo_empty;
                    end else begin
                        i2s_sdata <= sdata_bit(bit_next, left_reg, right_reg);
                    end
                end
            end
        end
    end

    // Underrun counter survives lock loss so software can still read how
    // often the stream starved before the PLL dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_cnt <= 8'd0;
        end else if (frame_wrap && fifo_empty && (underrun_cnt != 8'hFF)) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// ----------------------------------------------------------------------------
// tb_i2s_audio_tx
//
// Directed bench for i2s_audio_tx with CLK_DIV=2, SAMPLE_W=16, SLOT_W=32,
// FIFO_DEPTH=4. A BCLK period is 4 clk and a frame is 256 clk. Frames are
// captured bit by bit on BCLK rising edges and compared with hand-built
// {left, 16'h0, right, 16'h0} words.
// ----------------------------------------------------------------------------
module tb_i2s_audio_tx;

    localparam logic [63:0] LRCK_EXP = 64'h0000_0001_FFFF_FFFE;

    logic        clk;
    logic        reset;
    logic        pll_lock;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_sdata;
    logic        underrun;
    logic [7:0]  underrun_cnt;
    logic [2:0]  fifo_level;

    int check_count = 0;
    int fail_count  = 0;
    int ur_cycles   = 0;

    i2s_audio_tx #(
        .CLK_DIV   (2),
        .SAMPLE_W  (16),
        .SLOT_W    (32),
        .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_left     (in_left),
        .in_right    (in_right),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrck    (i2s_lrck),
        .i2s_sdata   (i2s_sdata),
        .underrun    (underrun),
        .underrun_cnt(underrun_cnt),
        .fifo_level  (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts clk cycles with the underrun pulse high; each underrun must add one.
    always @(negedge clk) begin
        if (underrun === 1'b1) begin
            ur_cycles++;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [63:0] frame_of(input logic [15:0] l, input logic [15:0] r);
        return {l, 16'h0000, r, 16'h0000};
    endfunction

    // Push one sample, waiting (bounded) for in_ready. Called at a negedge.
    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r);
        bit ok;
        ok       = 1'b0;
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (in_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("push_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_bclk_rise(output int cycles, output bit ok);
        logic last;
        last   = i2s_bclk;
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            cycles++;
            if (!last && i2s_bclk) begin
                ok = 1'b1;
                break;
            end
            last = i2s_bclk;
        end
    endtask

    task automatic skip_bits(input int n);
        int cyc;
        bit ok;
        for (int i = 0; i < n; i++) begin
            wait_bclk_rise(cyc, ok);
            if (!ok) begin
                checkOutput("bclk_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [63:0] exp_sd);
        logic [63:0] sd;
        logic [63:0] lr;
        int          bad;
        int          cyc;
        bit          ok;
        bit          all_ok;
        sd     = '0;
        lr     = '0;
        bad    = 0;
        all_ok = 1'b1;
        for (int k = 0; k < 64; k++) begin
            wait_bclk_rise(cyc, ok);
            if (!ok) begin
                all_ok = 1'b0;
                break;
            end
            sd[63-k] = i2s_sdata;
            lr[63-k] = i2s_lrck;
            if (k > 0 && cyc != 4) begin
                bad++;
            end
        end
        checkOutput({tag, "_done"}, 64'(all_ok), 64'd1);
        checkOutput({tag, "_sdata"}, sd, exp_sd);
        checkOutput({tag, "_lrck"}, lr, LRCK_EXP);
        checkOutput({tag, "_bclk_period"}, 64'(bad), 64'd0);
    endtask

    initial begin
        logic [15:0] s_left  [5];
        logic [15:0] s_right [5];
        bit          ok;

        s_left[0] = 16'h0001; s_right[0] = 16'h8000;
        s_left[1] = 16'hFFFF; s_right[1] = 16'h0000;
        s_left[2] = 16'h5A5A; s_right[2] = 16'hC3C3;
        s_left[3] = 16'h7FFF; s_right[3] = 16'h8001;
        s_left[4] = 16'h1357; s_right[4] = 16'h9BDF;

        reset    = 1'b1;
        pll_lock = 1'b0;
        in_valid = 1'b0;
        in_left  = '0;
        in_right = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_bclk", 64'(i2s_bclk), 64'd0);
        checkOutput("rst_lrck", 64'(i2s_lrck), 64'd0);
        checkOutput("rst_sdata", 64'(i2s_sdata), 64'd0);
        checkOutput("rst_underrun", 64'(underrun), 64'd0);
        checkOutput("rst_cnt", 64'(underrun_cnt), 64'd0);
        checkOutput("rst_level", 64'(fifo_level), 64'd0);
        checkOutput("rst_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("unlocked_ready", 64'(in_ready), 64'd0);

        // Lock, prime with one sample, first frame
        pll_lock = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("prime_ready", 64'(in_ready), 64'd1);
        applyStimulus(16'hA5C3, 16'h1234);
        checkOutput("prime_level", 64'(fifo_level), 64'd1);
        check_frame("frame1", frame_of(16'hA5C3, 16'h1234));

        // Underrun frame: silence, one pulse, count 1
        check_frame("underrun_frame", 64'd0);
        checkOutput("underrun_cnt1", 64'(underrun_cnt), 64'd1);
        checkOutput("underrun_pulse1", 64'(ur_cycles), 64'd1);

        // Lock loss mid-frame (next frame is another underrun)
        skip_bits(1);
        checkOutput("underrun_cnt2", 64'(underrun_cnt), 64'd2);
        checkOutput("underrun_pulse2", 64'(ur_cycles), 64'd2);
        applyStimulus(16'hDEAD, 16'hBEEF);
        checkOutput("pre_unlock_level", 64'(fifo_level), 64'd1);
        skip_bits(40);
        @(negedge clk);
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("unlock_bclk", 64'(i2s_bclk), 64'd0);
        checkOutput("unlock_lrck", 64'(i2s_lrck), 64'd0);
        checkOutput("unlock_sdata", 64'(i2s_sdata), 64'd0);
        checkOutput("unlock_level", 64'(fifo_level), 64'd0);
        checkOutput("unlock_ready", 64'(in_ready), 64'd0);
        checkOutput("unlock_cnt_kept", 64'(underrun_cnt), 64'd2);
        repeat (10) @(negedge clk);
        pll_lock = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("relock_ready", 64'(in_ready), 64'd1);
        checkOutput("relock_level", 64'(fifo_level), 64'd0);
        applyStimulus(16'h8001, 16'h7FFE);
        check_frame("relock_frame", frame_of(16'h8001, 16'h7FFE));
        checkOutput("relock_cnt_kept", 64'(underrun_cnt), 64'd2);

        // Fill the FIFO during an underrun frame, hold valid while full
        skip_bits(1);
        checkOutput("underrun_cnt3", 64'(underrun_cnt), 64'd3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(s_left[i], s_right[i]);
        end
        checkOutput("full_level", 64'(fifo_level), 64'd4);
        checkOutput("full_ready", 64'(in_ready), 64'd0);
        in_left  = s_left[4];
        in_right = s_right[4];
        in_valid = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("full_hold_level", 64'(fifo_level), 64'd4);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("full_reopen", 64'(ok), 64'd1);
        checkOutput("after_pop_level", 64'(fifo_level), 64'd3);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("refill_level", 64'(fifo_level), 64'd4);
        for (int i = 0; i < 5; i++) begin
            check_frame($sformatf("fifo_frame%0d", i), frame_of(s_left[i], s_right[i]));
        end
        checkOutput("no_underrun_while_full", 64'(underrun_cnt), 64'd3);

        // Push and pop in the same cycle at level 2
        skip_bits(1);
        checkOutput("underrun_cnt4", 64'(underrun_cnt), 64'd4);
        applyStimulus(16'hC001, 16'h0C30);
        applyStimulus(16'h3FFE, 16'hF00F);
        checkOutput("level2", 64'(fifo_level), 64'd2);
        skip_bits(63);
        @(negedge clk);
        checkOutput("pre_pushpop_ready", 64'(in_ready), 64'd1);
        in_left  = 16'h6B6B;
        in_right = 16'h9494;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("pushpop_level", 64'(fifo_level), 64'd2);
        check_frame("order_a", frame_of(16'hC001, 16'h0C30));
        check_frame("order_b", frame_of(16'h3FFE, 16'hF00F));
        check_frame("order_c", frame_of(16'h6B6B, 16'h9494));
        checkOutput("pushpop_cnt", 64'(underrun_cnt), 64'd4);

        // More than 251 further empty frames: counter must stick at 255
        repeat (256 * 256) @(negedge clk);
        checkOutput("cnt_saturated", 64'(underrun_cnt), 64'd255);

        // Asynchronous reset mid-frame, between clock edges
        applyStimulus(16'h4242, 16'h2424);
        skip_bits(1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_bclk", 64'(i2s_bclk), 64'd0);
        checkOutput("async_rst_lrck", 64'(i2s_lrck), 64'd0);
        checkOutput("async_rst_sdata", 64'(i2s_sdata), 64'd0);
        checkOutput("async_rst_cnt", 64'(underrun_cnt), 64'd0);
        checkOutput("async_rst_level", 64'(fifo_level), 64'd0);
        checkOutput("async_rst_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
